posit_decode: RTL and testbench

POSIT_DECODE -- requirements
Module: posit_decode

---
 rtl/common_pkg.sv | 26 ++
 rtl/posit_decode_if.sv | 34 +++
 rtl/posit_regime_cnt.sv | 27 ++
 rtl/two_comp.sv | 11 +
 rtl/posit_decode.sv | 113 +++++++++++
 tb/tb_posit_decode.sv | 159 +++++++++++++++
 6 files changed

// File: rtl/common_pkg.sv
// Shared posit types and width helpers for the decoder, adder and subtractor.
package common;

    // Upper bounds for the shared field record; users slice down to their own widths.
    localparam int SCALE_MAX_W = 16;
    localparam int FRAC_MAX_W  = 32;

    typedef struct packed {
        logic                          sign;
        logic signed [SCALE_MAX_W-1:0] scale;
        logic [FRAC_MAX_W-1:0]         frac;
        logic                          zero;
        logic                          nar;
    } posit_fields_t;

    // Signed scale width: must hold +/-(width-1)*2^es.
    function automatic int scale_w(input int width, input int es);
        return $clog2((width - 1) * (1 << es)) + 1;
    endfunction

    // Fraction bits left after sign, two-bit minimum regime and exponent.
    function automatic int frac_w(input int width, input int es);
        return width - es - 3;
    endfunction

endpackage

// File: rtl/posit_decode_if.sv
// Input/output handshake bundle of the posit decoder.
interface posit_decode_if
    import common::*;
#(
    parameter int WIDTH = 7,
    parameter int ES    = 1
);
    localparam int SCALE_W = scale_w(WIDTH, ES);
    localparam int FRAC_W  = frac_w(WIDTH, ES);

    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          in_posit;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_sign;
    logic signed [SCALE_W-1:0] out_scale;
    logic [FRAC_W-1:0]         out_frac;
    logic                      out_zero;
    logic                      out_nar;

    // Producer/consumer side.
    modport master (
        output in_valid, in_posit, out_ready,
        input  in_ready, out_valid, out_sign, out_scale, out_frac, out_zero, out_nar
    );

    // Decoder side.
    modport slave (
        input  in_valid, in_posit, out_ready,
        output in_ready, out_valid, out_sign, out_scale, out_frac, out_zero, out_nar
    );

endinterface

// File: rtl/posit_regime_cnt.sv
// Leading-run detector: length and polarity of the run starting at the MSB.
module posit_regime_cnt #(
    parameter int N     = 6,
    parameter int RUN_W = $clog2(N + 1)
) (
    input  logic [N-1:0]     bits,
    output logic [RUN_W-1:0] run_len,
    output logic             run_pol
);

    logic ended;

    // Count bits equal to the MSB until the first differing bit.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        run_pol = bits[N-1];
        run_len = '0;
        ended   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!ended) begin
                if (bits[i] == run_pol) run_len = run_len + RUN_W'(1);
                else                    ended   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/two_comp.sv
// Two's complement negation.
module two_comp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    assign y = ~a + WIDTH'(1);

endmodule

// File: rtl/posit_decode.sv
// Two-stage posit decoder: stage 1 extracts sign/flags/magnitude, stage 2 decodes regime, exponent, fraction.
module posit_decode
    import common::*;
#(
    parameter int WIDTH = 7,
    parameter int ES    = 1
) (
    input  logic          clk,
    input  logic          rst,
    posit_decode_if.slave bus
);

    localparam int SCALE_W = scale_w(WIDTH, ES);
    localparam int FRAC_W  = frac_w(WIDTH, ES);
    localparam int MAG_W   = WIDTH - 1;
    localparam int TAIL_W  = ES + FRAC_W;
    localparam int RUN_W   = $clog2(MAG_W + 1);

    logic              s1_valid, s2_valid;
    logic              s1_adv, s2_adv;
    logic              in_sign, in_zero, in_nar;
    logic [MAG_W-1:0]  neg_mag;
    logic              s1_sign, s1_zero, s1_nar;
    logic [MAG_W-1:0]  s1_mag;
    logic [RUN_W-1:0]  run_len;
    logic              run_pol;
    logic [TAIL_W-1:0] tail;
    logic [SCALE_W-1:0] run_ext, regime_k, dec_scale;
    logic [FRAC_W-1:0] dec_frac;

    // Pipeline advance: a stage moves when it is empty or its successor moves.
    always_comb begin
        s2_adv       = !s2_valid || bus.out_ready;
        s1_adv       = !s1_valid || s2_adv;
        bus.in_ready = s1_adv;
    end

    assign in_zero = (bus.in_posit == '0);
    assign in_nar  = bus.in_posit[WIDTH-1] && (bus.in_posit[MAG_W-1:0] == '0);
    assign in_sign = bus.in_posit[WIDTH-1] && !in_nar;

    // Low bits of a negated word depend only on the low bits, so the sign bit is left out.
    two_comp #(.WIDTH(MAG_W)) u_neg (
        .a (bus.in_posit[MAG_W-1:0]),
        .y (neg_mag)
    );

    // Stage 1: capture sign, special-value flags and magnitude.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_nar   <= 1'b0;
            s1_mag   <= '0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign <= in_sign;
                s1_zero <= in_zero;
                s1_nar  <= in_nar;
                s1_mag  <= in_sign ? neg_mag : bus.in_posit[MAG_W-1:0];
            end
        end
    end

    posit_regime_cnt #(.N(MAG_W), .RUN_W(RUN_W)) u_regime (
        .bits    (s1_mag),
        .run_len (run_len),
        .run_pol (run_pol)
    );

    // Stage 2 decode: skip the run and its terminator, then split exponent and fraction.
    always_comb begin
        // The run is at least one bit, so shifting the low TAIL_W bits by run-1
        // drops exactly run+1 leading bits; cut-off positions fill with zeros.
        tail      = s1_mag[TAIL_W-1:0] << (run_len - RUN_W'(1));
        run_ext   = SCALE_W'(run_len);
        regime_k  = run_pol ? (run_ext - SCALE_W'(1)) : (SCALE_W'(0) - run_ext);
        dec_scale = (regime_k << ES) | SCALE_W'(tail[TAIL_W-1 -: ES]);
        dec_frac  = tail[FRAC_W-1:0];
        if (s1_zero || s1_nar) begin
            dec_scale = '0;
            dec_frac  = '0;
        end
    end

    // Stage 2: output register, held while the consumer stalls.
    always_ff @(posedge clk) begin
        // NOTE: output data is reset as well so a fresh pipeline presents all-zero fields.
        if (rst) begin
            s2_valid      <= 1'b0;
            bus.out_sign  <= 1'b0;
            bus.out_scale <= '0;
            bus.out_frac  <= '0;
            bus.out_zero  <= 1'b0;
            bus.out_nar   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                bus.out_sign  <= s1_sign;
                bus.out_scale <= dec_scale;
                bus.out_frac  <= dec_frac;
                bus.out_zero  <= s1_zero;
                bus.out_nar   <= s1_nar;
            end
        end
    end

    assign bus.out_valid = s2_valid;

endmodule

// File: tb/tb_posit_decode.sv
// Self-checking bench for posit_decode at WIDTH=7, ES=1.
module tb_posit_decode;

    localparam int W  = 7;
    localparam int E  = 1;
    localparam int NV = 14;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    posit_decode_if #(.WIDTH(W), .ES(E)) bus ();

    posit_decode #(.WIDTH(W), .ES(E)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Expected record layout: {sign, scale[4:0], frac[2:0], zero, nar}.
    typedef struct {
        string      name;
        logic [6:0] posit;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[NV];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [10:0] fields();
        return {bus.out_sign, bus.out_scale, bus.out_frac, bus.out_zero, bus.out_nar};
    endfunction

    function automatic logic [10:0] f(logic s, logic [4:0] sc, logic [2:0] fr, logic z, logic n);
        return {s, sc, fr, z, n};
    endfunction

    // Bound on total run time.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        int idx, got, stale;
        logic saw_full, prev_stall;
        logic [11:0] held;

        vecs[0]  = '{"one",          7'b0100000, f(1'b0, 5'b00000, 3'b000, 1'b0, 1'b0)};
        vecs[1]  = '{"three_q",      7'b0101101, f(1'b0, 5'b00001, 3'b101, 1'b0, 1'b0)};
        vecs[2]  = '{"minus_one",    7'b1100000, f(1'b1, 5'b00000, 3'b000, 1'b0, 1'b0)};
        vecs[3]  = '{"maxpos",       7'b0111111, f(1'b0, 5'b01010, 3'b000, 1'b0, 1'b0)};
        vecs[4]  = '{"minpos",       7'b0000001, f(1'b0, 5'b10110, 3'b000, 1'b0, 1'b0)};
        vecs[5]  = '{"scale_m4",     7'b0001000, f(1'b0, 5'b11100, 3'b000, 1'b0, 1'b0)};
        vecs[6]  = '{"zero",         7'b0000000, f(1'b0, 5'b00000, 3'b000, 1'b1, 1'b0)};
        vecs[7]  = '{"nar",          7'b1000000, f(1'b0, 5'b00000, 3'b000, 1'b0, 1'b1)};
        vecs[8]  = '{"four",         7'b0110000, f(1'b0, 5'b00010, 3'b000, 1'b0, 1'b0)};
        vecs[9]  = '{"neg_three_q",  7'b1010011, f(1'b1, 5'b00001, 3'b101, 1'b0, 1'b0)};
        vecs[10] = '{"scale_m1",     7'b0011011, f(1'b0, 5'b11111, 3'b011, 1'b0, 1'b0)};
        vecs[11] = '{"exp_cut",      7'b0000011, f(1'b0, 5'b11001, 3'b000, 1'b0, 1'b0)};
        vecs[12] = '{"neg_maxpos",   7'b1000001, f(1'b1, 5'b01010, 3'b000, 1'b0, 1'b0)};
        vecs[13] = '{"neg_minpos",   7'b1111111, f(1'b1, 5'b10110, 3'b000, 1'b0, 1'b0)};

        // Reset state.
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_posit  = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_in_ready",  32'(bus.in_ready),  32'd1);
        check("reset_fields",    32'(fields()),      32'd0);

        // Table: each word alone, checking the two-cycle latency and the decoded fields.
        for (int i = 0; i < NV; i++) begin
            bus.in_valid = 1'b1;
            bus.in_posit = vecs[i].posit;
            @(negedge clk);
            bus.in_valid = 1'b0;
            check({vecs[i].name, "_lat1"}, 32'(bus.out_valid), 32'd0);
            @(negedge clk);
            check({vecs[i].name, "_lat2"}, 32'(bus.out_valid), 32'd1);
            check(vecs[i].name, 32'(fields()), 32'(vecs[i].exp));
        end

        // Eight back-to-back words with the consumer stalled in cycles 3-5.
        idx        = 0;
        got        = 0;
        saw_full   = 1'b0;
        prev_stall = 1'b0;
        held       = '0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(negedge clk);
            bus.out_ready = !(cyc >= 3 && cyc <= 5);
            bus.in_valid  = (idx < 8);
            bus.in_posit  = vecs[(idx < 8) ? idx : 0].posit;
            #1;
            if (prev_stall) check($sformatf("hold_cyc%0d", cyc), 32'({bus.out_valid, fields()}), 32'(held));
            if (cyc == 6) check("release_in_ready", 32'(bus.in_ready), 32'd1);
            if (!bus.in_ready) saw_full = 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                check($sformatf("stream_%0d", got), 32'(fields()), 32'(vecs[got].exp));
                got++;
            end
            if (bus.in_valid && bus.in_ready) idx++;
            prev_stall = bus.out_valid && !bus.out_ready;
            held       = {bus.out_valid, fields()};
        end
        check("stream_count", 32'(got), 32'd8);
        check("stream_backpressure", 32'(saw_full), 32'd1);

        // Reset with both stages occupied; a word presented during reset must be ignored.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_posit  = vecs[1].posit;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_posit  = vecs[3].posit;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        #1;
        check("flight_full", 32'({bus.out_valid, bus.in_ready}), 32'b10);
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_posit  = vecs[8].posit;
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        check("flush_fields",    32'(fields()),      32'd0);
        check("flush_in_ready",  32'(bus.in_ready),  32'd1);
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) stale++;
        end
        check("flush_no_stale", 32'(stale), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
